// File: rtl/router_pkg.sv
// Shared types and header layout for the router packet source.
// Header byte is {len, dest}: dest in [1:0], len in [7:2].
package router_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEST_W    = 2;
    localparam int DEST_LSB  = 0;
    localparam int LEN_HDR_W = 6;
    localparam int LEN_LSB   = 2;

    localparam logic [DEST_W-1:0] MAX_DEST = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    function automatic logic [BYTE_W-1:0] make_header(
        input logic [LEN_HDR_W-1:0] len,
        input logic [DEST_W-1:0]    dest
    );
        logic [BYTE_W-1:0] h;
        h = '0;
        h[LEN_LSB +: LEN_HDR_W] = len;
        h[DEST_LSB +: DEST_W]   = dest;
        return h;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for router_pkt_tx: sync write, async read.
// No reset; contents are don't-care until written.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: fill, header, payload, parity.
// Optional PKT_TX_PARITY_CORRUPT_EN adds corrupt_parity to invert parity.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int LEN_W      = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        start_dest,
    input  logic [LEN_W-1:0]  start_len,
`ifdef PKT_TX_PARITY_CORRUPT_EN
    input  logic              corrupt_parity,
`endif
    output logic              start_rdy,
    input  logic              pl_valid,
    input  logic [BYTE_W-1:0] pl_data,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [BYTE_W-1:0] data_out,
    output logic              tx_done,
    output logic              tx_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0]    GAP_ONE = 1;
    localparam logic [LEN_W-1:0] ONE     = 1;

    state_t state, state_d;

    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic [BYTE_W-1:0] parity, parity_d;
    logic              corrupt_q, corrupt_d;
    logic [GW-1:0]     gap_cnt, gap_d;

    logic              pkt_valid_d;
    logic [BYTE_W-1:0] data_out_d;
    logic              tx_done_d;
    logic              tx_err_d;

    logic              buf_we;
    logic [LEN_W-1:0]  rd_addr;
    logic [BYTE_W-1:0] rd_data;
    logic [BYTE_W-1:0] hdr;
    logic [LEN_W-1:0]  last_idx;

    assign start_rdy = (state == S_IDLE);
    assign pl_ready  = (state == S_FILL);
    assign hdr       = make_header(LEN_HDR_W'(len_q), dest_q);
    assign last_idx  = len_q - ONE;

    // Look one byte ahead so data_out is loaded on the transfer edge.
    assign rd_addr = (state == S_PAYLOAD) ? cnt + ONE : '0;

    router_tx_buf #(
        .AW(LEN_W)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_addr (cnt),
        .wr_data (pl_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            parity    <= '0;
            corrupt_q <= 1'b0;
            gap_cnt   <= '0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_d;
            dest_q    <= dest_d;
            len_q     <= len_d;
            cnt       <= cnt_d;
            parity    <= parity_d;
            corrupt_q <= corrupt_d;
            gap_cnt   <= gap_d;
            pkt_valid <= pkt_valid_d;
            data_out  <= data_out_d;
            tx_done   <= tx_done_d;
            tx_err    <= tx_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        dest_d      = dest_q;
        len_d       = len_q;
        cnt_d       = cnt;
        parity_d    = parity;
        corrupt_d   = corrupt_q;
        gap_d       = gap_cnt;
        pkt_valid_d = pkt_valid;
        data_out_d  = data_out;
        tx_done_d   = 1'b0;
        tx_err_d    = 1'b0;
        buf_we      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (start_dest > MAX_DEST || start_len == '0) begin
                        tx_err_d = 1'b1;
                    end else begin
                        dest_d   = start_dest;
                        len_d    = start_len;
                        cnt_d    = '0;
                        parity_d = make_header(LEN_HDR_W'(start_len),
                                               start_dest);
`ifdef PKT_TX_PARITY_CORRUPT_EN
                        corrupt_d = corrupt_parity;
`else
                        corrupt_d = 1'b0;
`endif
                        state_d  = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity ^ pl_data;
                    if (cnt == last_idx) begin
                        cnt_d       = '0;
                        pkt_valid_d = 1'b1;
                        data_out_d  = hdr;
                        state_d     = S_HEADER;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    data_out_d = rd_data;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (cnt == last_idx) begin
                        pkt_valid_d = 1'b0;
                        data_out_d  = corrupt_q ? ~parity : parity;
                        state_d     = S_PARITY;
                    end else begin
                        cnt_d      = cnt + ONE;
                        data_out_d = rd_data;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    tx_done_d  = 1'b1;
                    data_out_d = '0;
                    gap_d      = '0;
                    state_d    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_cnt + GAP_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx with a queue-based packet model.
// Covers PKT_TX_PARITY_CORRUPT_EN scenarios when that macro is defined.
module tb_router_pkt_tx;

    localparam int GAP = 2;
    localparam int LW  = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    start_dest = '0;
    logic [LW-1:0] start_len = '0;
    logic          start_rdy;
    logic          pl_valid = 1'b0;
    logic [7:0]    pl_data = '0;
    logic          pl_ready;
    logic          busy = 1'b0;
    logic          pkt_valid;
    logic [7:0]    data_out;
    logic          tx_done;
    logic          tx_err;
`ifdef PKT_TX_PARITY_CORRUPT_EN
    logic          corrupt_parity = 1'b0;
`endif

    int chk = 0;
    int pass = 0;

    logic [7:0] pay_in[$];
    logic [7:0] last_hdr;
    logic [7:0] last_par;

    always #5 clk = ~clk;

    router_pkt_tx #(
        .GAP_CYCLES(GAP),
        .LEN_W(LW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .start_dest (start_dest),
        .start_len  (start_len),
`ifdef PKT_TX_PARITY_CORRUPT_EN
        .corrupt_parity(corrupt_parity),
`endif
        .start_rdy  (start_rdy),
        .pl_valid   (pl_valid),
        .pl_data    (pl_data),
        .pl_ready   (pl_ready),
        .busy       (busy),
        .pkt_valid  (pkt_valid),
        .data_out   (data_out),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    task automatic test_reset();
        resetn = 1'b0;
        busy = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk++; if (pkt_valid !== 1'b0) $display("FAIL reset_pkt_valid got %0h exp 0", pkt_valid); else pass++;
        chk++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %0h exp 0", data_out); else pass++;
        chk++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done got %0h exp 0", tx_done); else pass++;
        chk++; if (tx_err !== 1'b0) $display("FAIL reset_tx_err got %0h exp 0", tx_err); else pass++;
        chk++; if (pl_ready !== 1'b0) $display("FAIL reset_pl_ready got %0h exp 0", pl_ready); else pass++;
        chk++; if (start_rdy !== 1'b1) $display("FAIL reset_start_rdy got %0h exp 1", start_rdy); else pass++;
    endtask

    // mode: 0 never busy, 1 random busy, 2 busy 3 cycles after header.
    task automatic run_packet(input logic [1:0] d, input int len,
                              input int mode, input bit corrupt,
                              input string tag);
        logic [7:0] exp_b[$];
        logic [7:0] pay[$];
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] prev_d;
        logic       prev_pv;
        bit         prev_busy;
        int         idx, cyc, ntx, busy_cyc;

        cyc = 0;
        while (start_rdy !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk++; if (start_rdy !== 1'b1) $display("FAIL %s start_rdy_wait got %0h exp 1", tag, start_rdy); else pass++;

        for (int i = 0; i < len; i++) begin
            if (pay_in.size() == len) pay.push_back(pay_in[i]);
            else pay.push_back(8'($urandom));
        end
        hdr = {6'(len), d};
        par = hdr;
        foreach (pay[i]) par ^= pay[i];
        if (corrupt) par = ~par;
        exp_b.push_back(hdr);
        foreach (pay[i]) exp_b.push_back(pay[i]);
        exp_b.push_back(par);

        start = 1'b1;
        start_dest = d;
        start_len = LW'(len);
`ifdef PKT_TX_PARITY_CORRUPT_EN
        corrupt_parity = corrupt;
`endif
        @(negedge clk);
        start = 1'b0;
        chk++; if (start_rdy !== 1'b0) $display("FAIL %s fill_start_rdy got %0h exp 0", tag, start_rdy); else pass++;

        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 2000) begin
            chk++; if (pl_ready !== 1'b1) $display("FAIL %s pl_ready got %0h exp 1", tag, pl_ready); else pass++;
            pl_valid = ($urandom_range(0, 3) != 0);
            pl_data = pay[idx];
            busy = $urandom_range(0, 1) == 1;
            @(posedge clk);
            if (pl_valid) idx++;
            @(negedge clk);
            cyc++;
        end
        pl_valid = 1'b0;
        busy = 1'b0;
        chk++; if (idx != len) $display("FAIL %s fill_timeout got %0d exp %0d", tag, idx, len); else pass++;
        chk++; if (pl_ready !== 1'b0) $display("FAIL %s pl_ready_after got %0h exp 0", tag, pl_ready); else pass++;

        ntx = 0;
        cyc = 0;
        busy_cyc = 0;
        prev_busy = 1'b0;
        prev_d = '0;
        prev_pv = 1'b0;
        while (ntx < len + 2 && cyc < len + 500) begin
            if (prev_busy) begin
                chk++; if (data_out !== prev_d || pkt_valid !== prev_pv) $display("FAIL %s hold got %0h/%0h exp %0h/%0h", tag, data_out, pkt_valid, prev_d, prev_pv); else pass++;
            end
            chk++; if (tx_done !== 1'b0) $display("FAIL %s early_tx_done got %0h exp 0", tag, tx_done); else pass++;
            case (mode)
                1: busy = ($urandom_range(0, 2) == 0);
                2: busy = (ntx == 1 && busy_cyc < 3);
                default: busy = 1'b0;
            endcase
            if (busy) busy_cyc++;
            if (!busy) begin
                chk++; if (data_out !== exp_b[ntx] || pkt_valid !== (ntx <= len)) $display("FAIL %s byte%0d got %0h/%0h exp %0h/%0h", tag, ntx, data_out, pkt_valid, exp_b[ntx], (ntx <= len)); else pass++;
                if (ntx == 0) last_hdr = data_out;
                if (ntx == len + 1) last_par = data_out;
                ntx++;
            end
            prev_busy = busy;
            prev_d = data_out;
            prev_pv = pkt_valid;
            @(negedge clk);
            cyc++;
        end
        busy = 1'b0;
        chk++; if (ntx != len + 2) $display("FAIL %s tx_timeout got %0d exp %0d", tag, ntx, len + 2); else pass++;
        if (mode == 2) begin
            chk++; if (busy_cyc != 3) $display("FAIL %s stall_count got %0d exp 3", tag, busy_cyc); else pass++;
        end

        chk++; if (tx_done !== 1'b1) $display("FAIL %s tx_done got %0h exp 1", tag, tx_done); else pass++;
        chk++; if (pkt_valid !== 1'b0 || data_out !== 8'h00) $display("FAIL %s post_parity got %0h/%0h exp 0/0", tag, pkt_valid, data_out); else pass++;
        chk++; if (start_rdy !== 1'b0) $display("FAIL %s gap_start_rdy got %0h exp 0", tag, start_rdy); else pass++;
        for (int k = 1; k <= GAP; k++) begin
            @(negedge clk);
            chk++; if (tx_done !== 1'b0) $display("FAIL %s tx_done_pulse got %0h exp 0", tag, tx_done); else pass++;
            chk++; if (start_rdy !== (k == GAP)) $display("FAIL %s gap%0d start_rdy got %0h exp %0h", tag, k, start_rdy, (k == GAP)); else pass++;
        end
    endtask

    task automatic test_basic();
        pay_in = '{8'hA1, 8'hB2, 8'hC3};
        run_packet(2'd1, 3, 0, 1'b0, "basic");
        chk++; if (last_hdr !== 8'h0D) $display("FAIL basic_header got %0h exp 0d", last_hdr); else pass++;
        chk++; if (last_par !== 8'hDD) $display("FAIL basic_parity got %0h exp dd", last_par); else pass++;
    endtask

    task automatic test_busy_stall();
        pay_in = '{8'hA1, 8'hB2, 8'hC3};
        run_packet(2'd1, 3, 2, 1'b0, "stall");
        chk++; if (last_par !== 8'hDD) $display("FAIL stall_parity got %0h exp dd", last_par); else pass++;
    endtask

    task automatic test_errors();
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            start_dest = (t == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            start_len = (t == 0) ? LW'($urandom) : '0;
            @(negedge clk);
            start = 1'b0;
            chk++; if (tx_err !== 1'b1) $display("FAIL err%0d tx_err got %0h exp 1", t, tx_err); else pass++;
            chk++; if (pkt_valid !== 1'b0) $display("FAIL err%0d pkt_valid got %0h exp 0", t, pkt_valid); else pass++;
            chk++; if (start_rdy !== 1'b1) $display("FAIL err%0d start_rdy got %0h exp 1", t, start_rdy); else pass++;
            @(negedge clk);
            chk++; if (tx_err !== 1'b0) $display("FAIL err%0d tx_err_pulse got %0h exp 0", t, tx_err); else pass++;
        end
    endtask

    task automatic test_max_len();
        pay_in = {};
        for (int i = 0; i < 63; i++) pay_in.push_back(8'hFF);
        run_packet(2'd0, 63, 0, 1'b0, "maxlen");
        chk++; if (last_hdr !== 8'hFC) $display("FAIL maxlen_header got %0h exp fc", last_hdr); else pass++;
        chk++; if (last_par !== 8'h03) $display("FAIL maxlen_parity got %0h exp 03", last_par); else pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] pay[4];
        foreach (pay[i]) pay[i] = 8'($urandom);
        start = 1'b1;
        start_dest = 2'd2;
        start_len = LW'(4);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pl_valid = 1'b1;
            pl_data = pay[i];
            @(negedge clk);
        end
        pl_valid = 1'b0;
        chk++; if (data_out !== 8'h12 || pkt_valid !== 1'b1) $display("FAIL rstmid_header got %0h/%0h exp 12/1", data_out, pkt_valid); else pass++;
        @(negedge clk);
        @(negedge clk);
        chk++; if (data_out !== pay[1]) $display("FAIL rstmid_byte1 got %0h exp %0h", data_out, pay[1]); else pass++;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk++; if (pkt_valid !== 1'b0) $display("FAIL rstmid_pkt_valid got %0h exp 0", pkt_valid); else pass++;
        chk++; if (data_out !== 8'h00) $display("FAIL rstmid_data_out got %0h exp 0", data_out); else pass++;
        chk++; if (start_rdy !== 1'b1) $display("FAIL rstmid_start_rdy got %0h exp 1", start_rdy); else pass++;
        chk++; if (pl_ready !== 1'b0) $display("FAIL rstmid_pl_ready got %0h exp 0", pl_ready); else pass++;
        pay_in = {};
        run_packet(2'd2, 5, 1, 1'b0, "rstmid_fresh");
    endtask

    task automatic test_random();
        pay_in = {};
        for (int n = 0; n < 10; n++) begin
            run_packet(2'($urandom_range(0, 2)),
                       (n < 5) ? $urandom_range(1, 8) : $urandom_range(1, 63),
                       1, 1'b0, "random");
        end
    endtask

`ifdef PKT_TX_PARITY_CORRUPT_EN
    task automatic test_corrupt();
        pay_in = '{8'hA1, 8'hB2, 8'hC3};
        run_packet(2'd1, 3, 0, 1'b1, "corrupt");
        chk++; if (last_par !== 8'h22) $display("FAIL corrupt_parity got %0h exp 22", last_par); else pass++;
        chk++; if (last_hdr !== 8'h0D) $display("FAIL corrupt_header got %0h exp 0d", last_hdr); else pass++;
        run_packet(2'd1, 3, 0, 1'b0, "uncorrupt");
        chk++; if (last_par !== 8'hDD) $display("FAIL uncorrupt_parity got %0h exp dd", last_par); else pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_errors();
        test_max_len();
        test_reset_mid();
        test_random();
`ifdef PKT_TX_PARITY_CORRUPT_EN
        test_corrupt();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port. It accepts a destination/length request, stores the payload, then transmits the router's input protocol:
- header byte with pkt_valid=1
- payload bytes with pkt_valid=1
- parity byte with pkt_valid=0

It stalls on the router's busy. It is used as the traffic driver in system test and as the host-side packet injector.

Parameters:
GAP_CYCLES, 2, idle cycles after parity before start_rdy re-asserts (covers router parity check / decode)
LEN_W, 6, payload length field width; max payload 2^LEN_W-1 bytes; header = {len, dest}

Ports:
clk  input  1  clock, all logic on posedge
resetn  input  1  synchronous, active-low reset
start  input  1  request strobe, accepted when start && start_rdy at a clock edge
start_dest  input  2  destination port 0..2
start_len  input  LEN_W  payload length, 1..63
start_rdy  output  1  high only in IDLE
pl_valid  input  1  payload byte valid
pl_data  input  8  payload byte
pl_ready  output  1  high only in FILL
busy  input  1  router busy; a byte transfers only on an edge where busy==0
pkt_valid  output  1  router packet-valid, registered
data_out  output  8  router data_in, registered
tx_done  output  1  one-cycle pulse on the edge the parity byte transfers
tx_err  output  1  one-cycle pulse for a rejected request

Behaviour:
- Reset values: state IDLE; pkt_valid=0, data_out=0, tx_done=0, tx_err=0, pl_ready=0, start_rdy=1 (first cycle after reset release); counters and parity cleared.
- States are IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start with start_dest==3 or start_len==0: tx_err=1 the next cycle; stay IDLE.
  - Valid start: latch dest and len; parity<={len,dest}; byte count=0; go to FILL.
- FILL:
  - Each edge with pl_valid&&pl_ready writes pl_data to buffer[count], XORs it into parity, and increments count.
  - The edge accepting byte len-1 moves to HEADER; pl_ready=0 from the next cycle.
  - start is ignored outside IDLE.
- HEADER:
  - pkt_valid=1, data_out={len,dest}, both loaded on the FILL->HEADER edge.
  - Edge with busy==0: go to PAYLOAD; data_out<=buffer[0].
  - busy==1: hold outputs unchanged.
- PAYLOAD:
  - pkt_valid=1, data_out=buffer[idx].
  - Edge with busy==0: idx++ and data_out<=buffer[idx+1].
  - After the last byte (idx==len-1) transfers: pkt_valid<=0, data_out<=parity, go to PARITY.
  - Outputs must hold stable whenever busy==1; no byte is skipped or duplicated.
- PARITY:
  - Edge with busy==0: tx_done=1 for one cycle; data_out<=0; go to GAP.
- GAP:
  - Counts GAP_CYCLES cycles with pkt_valid=0, then returns to IDLE.
- Throughput: with busy held 0, header through parity occupies len+2 consecutive cycles.
- pkt_valid never drops mid-payload. pkt_valid falls exactly on the cycle the parity byte is presented.
- Counters are LEN_W bits wide; len=63 must not wrap before the last byte.
- resetn low in any state: next cycle returns to IDLE with reset values. The partial packet is abandoned and the buffer contents are don't-care.
- No combinational path from busy or pl_valid to any output.

Optional Feature:
Macro PKT_TX_PARITY_CORRUPT_EN.
- Defined:
  - Adds input corrupt_parity (1 bit), sampled with an accepted start.
  - If it was set, the transmitted parity byte is bitwise inverted. This is for exercising router parity-error detection.
- Undefined:
  - Port absent; parity is always the correct header-XOR-payload.

Decomposition:
- Shared package router_pkg holds:
  - the state enum
  - header field positions (dest [1:0], len [7:2])
  - MAX_DEST=2
  - the byte width constant of 8
- One sub-module, router_tx_buf:
  - 2^LEN_W x 8 storage
  - synchronous write port, combinational read port
  - instantiated once; the FSM owns all pointers.

Test Plan:
1. dest=1, len=3, payload A1,B2,C3, busy=0 -> data_out 0x0D, A1, B2, C3 with pkt_valid=1, then 0xDD with pkt_valid=0; tx_done pulses once; start_rdy high GAP_CYCLES cycles later.
2. Same packet with busy=1 for 3 cycles after the header transfers -> A1 held 3 cycles, then B2, C3, 0xDD; never two payload bytes in one transfer cycle.
3. start with dest=3 (any len), and start with len=0 -> tx_err pulse, pkt_valid stays 0, start_rdy stays 1.
4. dest=0, len=63, all payload 0xFF -> header 0xFC, 63 bytes of 0xFF, parity 0x03; exactly 65 transfer cycles.
5. resetn low for one cycle during the 2nd payload byte -> next cycle pkt_valid=0, data_out=0, start_rdy=1; a fresh packet afterwards is correct.
6. With PKT_TX_PARITY_CORRUPT_EN and corrupt_parity=1 on scenario 1 -> parity byte 0x22; all other bytes unchanged.
